// File: rtl/rr_mux_pkg.sv
// Shared types and helpers for the round-robin mux pipe.
// Holds the arbiter state enum and the clog2 constant function.
package rr_mux_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_mux_pipe_pick.sv
// Rotate-priority encoder: first requester at or after ptr,
// wrapping modulo NCH.
module rr_pick
  import rr_mux_pkg::*;
#(
  parameter int NCH = 4,
  localparam int CHW = (NCH > 1) ? clog2(NCH) : 1
) (
  input  logic [NCH-1:0] req,
  input  logic [CHW-1:0] ptr,
  output logic [CHW-1:0] gnt_idx,
  output logic           any
);

  localparam int NP = 1 << CHW;

  logic [NP-1:0] req_pad;
  logic [CHW:0]  idx;

  // Walk from farthest to nearest so the closest hit wins.
  always_comb begin
    req_pad = NP'(req);
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (CHW+1)'(k);
      if (idx >= (CHW+1)'(NCH))
        idx = idx - (CHW+1)'(NCH);
      if (req_pad[idx[CHW-1:0]]) begin
        gnt_idx = idx[CHW-1:0];
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_mux_pipe.sv
// N-channel round-robin mux with a registered output stage,
// valid/ready on every port and optional packet lock.
module rr_mux_pipe
  import rr_mux_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int NCH      = 4,
  parameter int PKT_MODE = 0,
  localparam int CHW = (NCH > 1) ? clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_last,
  output logic [CHW-1:0]       out_chan
);

  localparam int NP = 1 << CHW;

  state_t         state, state_n;
  logic [CHW-1:0] ptr, ptr_n;
  logic [CHW-1:0] lch, lch_n;
  logic [CHW-1:0] pick, gnt, gnt_inc;
  logic [CHW:0]   inc;
  logic           any, locked;
  logic           gnt_ok, load, acc;
  logic [NP-1:0]  vld_pad, last_pad, rdy_pad;
  logic [WIDTH-1:0] ch_data [NP];

  for (genvar i = 0; i < NP; i++) begin : g_ch
    if (i < NCH) begin : g_real
      assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
    end else begin : g_pad
      assign ch_data[i] = '0;
    end
  end

  rr_pick #(
    .NCH(NCH)
  ) u_pick (
    .req    (in_valid),
    .ptr    (ptr),
    .gnt_idx(pick),
    .any    (any)
  );

  always_comb begin
    vld_pad  = NP'(in_valid);
    last_pad = NP'(in_last);
    load     = !out_valid || out_ready;
    locked   = (PKT_MODE != 0) && (state == LOCK);
    gnt      = locked ? lch : pick;
    gnt_ok   = locked ? vld_pad[lch] : any;
    acc      = rst_n && load && gnt_ok;
    rdy_pad  = '0;
    if (acc)
      rdy_pad[gnt] = 1'b1;
    in_ready = rdy_pad[NCH-1:0];
    inc      = {1'b0, gnt} + (CHW+1)'(1);
    gnt_inc  = (inc >= (CHW+1)'(NCH)) ? '0
                                      : inc[CHW-1:0];
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    lch_n   = lch;
    if (acc) begin
      if (PKT_MODE == 0 || last_pad[gnt]) begin
        ptr_n   = gnt_inc;
        state_n = ARB;
      end else begin
        state_n = LOCK;
        lch_n   = gnt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB;
      ptr   <= '0;
      lch   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      lch   <= lch_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_chan  <= '0;
    end else if (acc) begin
      out_valid <= 1'b1;
      out_data  <= ch_data[gnt];
      out_last  <= last_pad[gnt];
      out_chan  <= gnt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux_pipe.sv
// Self-checking bench for rr_mux_pipe across four configurations.
// Expected beats are queued at handshake and popped at the output.
module tb_rr_mux_pipe;

  typedef struct {
    int c;
    int d;
    bit l;
  } beat_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  beat_t q[$];

  logic [3:0]  v4, r4, l4;
  logic [31:0] d4;
  logic        ov4, or4, ol4;
  logic [7:0]  od4;
  logic [1:0]  oc4;

  logic [2:0]  v3, r3, l3;
  logic [23:0] d3;
  logic        ov3, or3, ol3;
  logic [7:0]  od3;
  logic [1:0]  oc3;

  logic [3:0]  vp, rp, lp;
  logic [31:0] dp;
  logic        ovp, orp, olp;
  logic [7:0]  odp;
  logic [1:0]  ocp;

  logic [0:0]  v1, r1, l1, d1, od1, oc1;
  logic        ov1, or1, ol1;

  rr_mux_pipe #(.WIDTH(8), .NCH(4), .PKT_MODE(0)) u4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v4), .in_ready(r4), .in_data(d4), .in_last(l4),
    .out_valid(ov4), .out_ready(or4), .out_data(od4),
    .out_last(ol4), .out_chan(oc4)
  );

  rr_mux_pipe #(.WIDTH(8), .NCH(3), .PKT_MODE(0)) u3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v3), .in_ready(r3), .in_data(d3), .in_last(l3),
    .out_valid(ov3), .out_ready(or3), .out_data(od3),
    .out_last(ol3), .out_chan(oc3)
  );

  rr_mux_pipe #(.WIDTH(8), .NCH(4), .PKT_MODE(1)) up (
    .clk(clk), .rst_n(rst_n),
    .in_valid(vp), .in_ready(rp), .in_data(dp), .in_last(lp),
    .out_valid(ovp), .out_ready(orp), .out_data(odp),
    .out_last(olp), .out_chan(ocp)
  );

  rr_mux_pipe #(.WIDTH(1), .NCH(1), .PKT_MODE(0)) u1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v1), .in_ready(r1), .in_data(d1), .in_last(l1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1),
    .out_last(ol1), .out_chan(oc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    v4 = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ov4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got %b want 0", ov4);
    end
    checks++;
    if (od4 !== 8'h00) begin
      errors++;
      $display("FAIL reset_out_data got %h want 00", od4);
    end
    checks++;
    if (oc4 !== 2'd0 || ol4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_chan_last got %0d/%b want 0/0", oc4, ol4);
    end
    checks++;
    if (r4 !== 4'b0000) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 0000", r4);
    end
    rst_n = 1'b1;
    v4 = '0;
  endtask

  task automatic test_round_robin();
    int ch;
    q.delete();
    d4  = {8'h43, 8'h32, 8'h21, 8'h10};
    l4  = '0;
    or4 = 1'b1;
    v4  = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (i == 0) begin
        if (ov4 !== 1'b0) begin
          errors++;
          $display("FAIL rr_first_latency got %b want 0", ov4);
        end
      end else begin
        if (ov4 !== 1'b1 || int'(oc4) !== q[0].c
            || int'(od4) !== q[0].d) begin
          errors++;
          $display("FAIL rr_beat%0d got v=%b c=%0d d=%h want c=%0d d=%h",
                   i, ov4, oc4, od4, q[0].c, q[0].d);
        end
        void'(q.pop_front());
      end
      ch = i % 4;
      checks++;
      if (r4 !== 4'(1 << ch)) begin
        errors++;
        $display("FAIL rr_ready%0d got %b want %b", i, r4, 4'(1 << ch));
      end
      q.push_back('{c: ch, d: int'(d4[ch*8 +: 8]), l: 1'b0});
      @(negedge clk);
    end
  endtask

  task automatic test_back_pressure();
    or4 = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      checks++;
      if (ov4 !== 1'b1 || od4 !== 8'h21 || oc4 !== 2'd1) begin
        errors++;
        $display("FAIL bp_hold%0d got v=%b d=%h c=%0d want 1/21/1",
                 j, ov4, od4, oc4);
      end
      checks++;
      if (r4 !== 4'b0000) begin
        errors++;
        $display("FAIL bp_ready%0d got %b want 0000", j, r4);
      end
      @(negedge clk);
    end
    or4 = 1'b1;
    #1;
    checks++;
    if (r4 !== 4'b0100) begin
      errors++;
      $display("FAIL bp_release_ready got %b want 0100", r4);
    end
    void'(q.pop_front());
    q.push_back('{c: 2, d: 'h32, l: 1'b0});
    @(negedge clk);
    v4 = '0;
    #1;
    checks++;
    if (ov4 !== 1'b1 || int'(oc4) !== q[0].c || int'(od4) !== q[0].d) begin
      errors++;
      $display("FAIL bp_next got v=%b c=%0d d=%h want c=%0d d=%h",
               ov4, oc4, od4, q[0].c, q[0].d);
    end
    void'(q.pop_front());
    @(negedge clk);
    checks++;
    if (ov4 !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain got %b want 0", ov4);
    end
  endtask

  task automatic test_nch3();
    logic [2:0] tv [7];
    int         tc [7];
    tv = '{3'b100, 3'b101, 3'b111, 3'b111, 3'b111, 3'b111, 3'b000};
    tc = '{2, 0, 1, 2, 0, 1, -1};
    q.delete();
    d3  = {8'h62, 8'h51, 8'h40};
    l3  = '0;
    or3 = 1'b1;
    for (int i = 0; i <= 7; i++) begin
      if (i < 7) v3 = tv[i];
      #1;
      checks++;
      if (q.size() > 0) begin
        if (ov3 !== 1'b1 || int'(oc3) !== q[0].c
            || int'(od3) !== q[0].d || oc3 == 2'd3) begin
          errors++;
          $display("FAIL n3_beat%0d got v=%b c=%0d d=%h want c=%0d d=%h",
                   i, ov3, oc3, od3, q[0].c, q[0].d);
        end
        void'(q.pop_front());
      end else if (ov3 !== 1'b0) begin
        errors++;
        $display("FAIL n3_idle%0d got %b want 0", i, ov3);
      end
      if (i < 7) begin
        checks++;
        if (tc[i] >= 0) begin
          if (r3 !== 3'(1 << tc[i])) begin
            errors++;
            $display("FAIL n3_ready%0d got %b want %b",
                     i, r3, 3'(1 << tc[i]));
          end
          q.push_back('{c: tc[i], d: int'(d3[tc[i]*8 +: 8]), l: 1'b0});
        end else if (r3 !== 3'b000) begin
          errors++;
          $display("FAIL n3_ready%0d got %b want 000", i, r3);
        end
      end
      @(negedge clk);
    end
    v3 = '0;
  endtask

  task automatic test_packet();
    logic [3:0] tv [7];
    logic [3:0] tl [7];
    logic [7:0] td [7];
    logic [3:0] tr [7];
    int         ch;
    tv = '{4'b0001, 4'b0111, 4'b0111, 4'b0101, 4'b0111, 4'b0101, 4'b0000};
    tl = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0111, 4'b0000};
    td = '{8'hA0, 8'hA0, 8'hA1, 8'hA1, 8'hA2, 8'hA2, 8'hA2};
    tr = '{4'b0001, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0100, 4'b0000};
    q.delete();
    orp = 1'b1;
    for (int i = 0; i <= 7; i++) begin
      if (i < 7) begin
        vp = tv[i];
        lp = tl[i];
        dp = {8'h33, 8'h22, td[i], 8'h0C};
      end
      #1;
      checks++;
      if (q.size() > 0) begin
        if (ovp !== 1'b1 || int'(ocp) !== q[0].c
            || int'(odp) !== q[0].d || olp !== q[0].l) begin
          errors++;
          $display("FAIL pkt_beat%0d got v=%b c=%0d d=%h l=%b want c=%0d d=%h l=%b",
                   i, ovp, ocp, odp, olp, q[0].c, q[0].d, q[0].l);
        end
        void'(q.pop_front());
      end else if (ovp !== 1'b0) begin
        errors++;
        $display("FAIL pkt_idle%0d got %b want 0", i, ovp);
      end
      if (i < 7) begin
        checks++;
        if (rp !== tr[i]) begin
          errors++;
          $display("FAIL pkt_ready%0d got %b want %b", i, rp, tr[i]);
        end
        ch = -1;
        for (int b = 0; b < 4; b++)
          if (tr[i][b]) ch = b;
        if (ch >= 0)
          q.push_back('{c: ch, d: int'(dp[ch*8 +: 8]), l: tl[i][ch]});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    vp  = 4'b0010;
    lp  = 4'b0000;
    dp  = {8'h33, 8'h22, 8'hB7, 8'h0C};
    orp = 1'b1;
    #1;
    checks++;
    if (rp !== 4'b0010) begin
      errors++;
      $display("FAIL ar_pre_ready got %b want 0010", rp);
    end
    @(negedge clk);
    orp = 1'b0;
    #1;
    checks++;
    if (ovp !== 1'b1 || odp !== 8'hB7 || ocp !== 2'd1) begin
      errors++;
      $display("FAIL ar_held got v=%b d=%h c=%0d want 1/b7/1", ovp, odp, ocp);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ovp !== 1'b0 || odp !== 8'h00 || olp !== 1'b0 || ocp !== 2'd0) begin
      errors++;
      $display("FAIL ar_clear got v=%b d=%h l=%b c=%0d want 0/00/0/0",
               ovp, odp, olp, ocp);
    end
    checks++;
    if (rp !== 4'b0000) begin
      errors++;
      $display("FAIL ar_ready_in_reset got %b want 0000", rp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    vp  = 4'b1111;
    lp  = 4'b1111;
    orp = 1'b1;
    #1;
    checks++;
    if (rp !== 4'b0001) begin
      errors++;
      $display("FAIL ar_restart got %b want 0001", rp);
    end
    @(negedge clk);
    vp = '0;
    lp = '0;
    #1;
    checks++;
    if (ovp !== 1'b1 || ocp !== 2'd0 || odp !== 8'h0C) begin
      errors++;
      $display("FAIL ar_first got v=%b c=%0d d=%h want 1/0/0c", ovp, ocp, odp);
    end
    @(negedge clk);
  endtask

  task automatic test_nch1();
    logic [0:0] seq [3];
    seq = '{1'b1, 1'b0, 1'b1};
    q.delete();
    or1 = 1'b1;
    l1  = 1'b0;
    for (int i = 0; i <= 4; i++) begin
      if (i < 3) begin
        v1 = 1'b1;
        d1 = seq[i];
      end else begin
        v1 = 1'b0;
      end
      #1;
      checks++;
      if (q.size() > 0) begin
        if (ov1 !== 1'b1 || int'(od1) !== q[0].d || oc1 !== 1'b0) begin
          errors++;
          $display("FAIL n1_beat%0d got v=%b d=%b c=%b want d=%0d c=0",
                   i, ov1, od1, oc1, q[0].d);
        end
        void'(q.pop_front());
      end else if (ov1 !== 1'b0) begin
        errors++;
        $display("FAIL n1_idle%0d got %b want 0", i, ov1);
      end
      if (i < 3) begin
        checks++;
        if (r1 !== 1'b1) begin
          errors++;
          $display("FAIL n1_ready%0d got %b want 1", i, r1);
        end
        q.push_back('{c: 0, d: int'(seq[i]), l: 1'b0});
      end
      @(negedge clk);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    v4 = '0; d4 = '0; l4 = '0; or4 = 1'b0;
    v3 = '0; d3 = '0; l3 = '0; or3 = 1'b0;
    vp = '0; dp = '0; lp = '0; orp = 1'b0;
    v1 = '0; d1 = '0; l1 = '0; or1 = 1'b0;
    test_reset();
    @(negedge clk);
    test_round_robin();
    test_back_pressure();
    test_nch3();
    test_packet();
    test_async_reset();
    test_nch1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_mux_pipe.md
Name: rr_mux_pipe

Overview:
- Parametrised N-channel, W-bit round-robin multiplexer with a registered output stage and a valid/ready handshake on every port.
- Generalises the two-input 1-bit select primitive that the ASIC mapping flow targets with MUX2 cells. Adds width, channel count, fair arbitration, back-pressure and an optional packet-lock mode.
- Serves as a benchmark and regression block for sequential tech mapping: MUX2 trees feeding DFFs with asynchronous reset.

Parameters:
- WIDTH, 8, data bits per channel (>=1).
- NCH, 4, number of input channels (>=1).
- PKT_MODE, 0, 0 = re-arbitrate after every beat; 1 = hold grant until an accepted beat with in_last=1.
- CHW, derived, max(1, clog2(NCH)); width of channel index. Not user-overridable.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  NCH  per-channel beat valid.
- in_ready  output  NCH  per-channel accept; at most one bit high per cycle.
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_last  input  NCH  end-of-packet marker; used only when PKT_MODE=1.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  downstream accept.
- out_data  output  WIDTH  registered data.
- out_last  output  1  registered copy of accepted in_last.
- out_chan  output  CHW  index of the channel that supplied the current beat.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_last=0, out_chan=0, ptr=0, state=ARB. in_ready=0 while rst_n is low. Reset mid-packet discards the lock and any held beat.
- load = !out_valid || out_ready. A single output register is used, so a new beat may enter in the same cycle the held one leaves: 1 beat/cycle throughput, 1-cycle latency from in_valid to out_valid.
- ARB state: grant g = first i in ptr, ptr+1, …, NCH-1, 0, …, ptr-1 with in_valid[i]=1.
  - in_ready[g] = load; all other in_ready bits are 0.
  - in_ready is combinational from in_valid, out_valid, out_ready and state.
  - No requester: in_ready is all 0 and the register drains normally.
- Accept (in_valid[g] && in_ready[g]) at a clock edge:
  - out_data <= channel g data, out_last <= in_last[g], out_chan <= g, out_valid <= 1.
  - If nothing is accepted and out_ready=1, out_valid <= 0.
- Pointer update:
  - PKT_MODE=0: on every accept, ptr <= (g+1) mod NCH.
  - PKT_MODE=1: accept with in_last=1 sets ptr <= (g+1) mod NCH and stays in ARB. Accept with in_last=0 enters LOCK with lch=g.
- LOCK state (PKT_MODE=1 only):
  - Only channel lch is eligible: in_ready[lch] = load, all others 0. Other channels wait even if lch is idle.
  - Accept with in_last=1 returns to ARB and sets ptr <= (lch+1) mod NCH.
- Wrap-around: the pointer modulo is NCH, not 2^CHW. Non-power-of-two NCH, e.g. 3, must never select index 3.
- NCH=1: degenerate registered pipe. out_chan is constantly 0 and ptr is constant.
- Held beat: out_data, out_last and out_chan remain stable while out_valid=1 and out_ready=0.
- Upstream rule: data is sampled only on handshake. in_valid may drop without a handshake; the block does not check for this.
- All arithmetic is unsigned; ptr increment is computed in CHW+1 bits before the modulo compare.

Decomposition:
- Shared package rr_mux_pkg:
  - clog2 constant function;
  - state enum {ARB, LOCK} (1 bit).
- One natural sub-module, rr_pick: combinational rotate-priority encoder with inputs req[NCH] and ptr[CHW], outputs gnt_idx[CHW] and any. It is reusable by other arbiters and maps to a MUX2/AND-OR tree.
- rr_mux_pipe holds the data mux, output register, pointer and lock FSM.

Test Plan:
- Reset, then NCH=4, WIDTH=8, PKT_MODE=0. All four valid with data 0x10/0x21/0x32/0x43, out_ready=1 → out_chan 0,1,2,3,0… on consecutive cycles, out_data follows, first out_valid one cycle after the first accept.
- Back-pressure: out_ready=0 for 3 cycles with a beat held (0x21, chan 1) → out_data/out_chan stable, in_ready=0000. out_ready=1 → next beat is accepted the same cycle (no bubble).
- NCH=3: only ch2 valid, then ch0 and ch2 valid → grants go to ch2, then ch0 (pointer wrapped 3→0). Index 3 is never produced.
- PKT_MODE=1: ch1 sends 3 beats (last on the third) while ch0 and ch2 stay valid. ch1 idles one cycle mid-packet → ch0/ch2 in_ready=0 during the gap, then ch2 is granted next (ptr=2).
- Async reset asserted mid-packet with out_valid=1 → out_valid, out_data, out_last and out_chan go to 0 immediately. After release, arbitration restarts at ch0 in ARB.
- NCH=1, WIDTH=1: data stream 1,0,1 with out_ready=1 → same sequence on out_data, delayed 1 cycle, out_chan=0.
